// File: rtl/if_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : if_fetcher
// Description : Instruction fetch stage with a direct-mapped, one-word-per-line
//               instruction cache. It holds the PC, fills missing lines through
//               a single-word request/done handshake, and presents one
//               instruction per cycle over a valid/ready handshake with a static
//               next-PC prediction (JAL and backward branches predicted taken).
//               A redirect restarts fetch at a new PC.
// Ports       :
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; 0 freezes all state
//   mem_req/addr    line-fill request (held for the whole miss) and word address
//   mem_done/data   one-cycle fill completion pulse and returned word
//   inst_valid/inst/inst_pc/inst_pred_jump  output register to the decoder
//   inst_ready      downstream accept
//   redirect/redirect_pc  restart request from the ROB
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetcher #(
    parameter int ICACHE_LINES = 256,
    parameter int INDEX_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_pred_jump,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int c_tag_w = 30 - INDEX_W;

    localparam logic [0:0] c_st_fetch     = 1'b0;
    localparam logic [0:0] c_st_miss_wait = 1'b1;

    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]              r_state;
    logic [31:0]             r_pc;
    logic [ICACHE_LINES-1:0] r_valid;
    logic [c_tag_w-1:0]      r_tag  [ICACHE_LINES];
    logic [31:0]             r_data [ICACHE_LINES];

    // ------------------------------------------------------------------
    // Lookup and prediction
    // ------------------------------------------------------------------
    logic [INDEX_W-1:0] w_index;
    logic [INDEX_W-1:0] w_fill_index;
    logic [c_tag_w-1:0] w_pc_tag;
    logic               w_hit;
    logic [31:0]        w_word;
    logic               w_out_free;
    logic               w_fill_wr;
    logic [31:0]        w_imm_j;
    logic [31:0]        w_imm_b;
    logic               w_is_jal;
    logic               w_is_bwd_branch;
    logic [31:0]        w_next_pc;
    logic               w_pred;

    assign w_index      = r_pc[INDEX_W+1:2];
    assign w_pc_tag     = r_pc[31:INDEX_W+2];
    assign w_fill_index = mem_addr[INDEX_W+1:2];
    assign w_word       = r_data[w_index];
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_pc_tag);

    // The output register can take a new word if it is empty or being drained.
    assign w_out_free   = !inst_valid || inst_ready;

    // Fill writes only happen while a request is outstanding and enabled.
    assign w_fill_wr    = rdy && (r_state == c_st_miss_wait) && mem_done;

    // RISC-V J- and B-type immediates, sign-extended to 32 bits.
    assign w_imm_j = {{12{w_word[31]}}, w_word[19:12], w_word[20], w_word[30:21], 1'b0};
    assign w_imm_b = {{20{w_word[31]}}, w_word[7], w_word[30:25], w_word[11:8], 1'b0};

    assign w_is_jal        = (w_word[6:0] == c_op_jal);
    assign w_is_bwd_branch = (w_word[6:0] == c_op_branch) && w_word[31];

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        w_pred    = 1'b0;
        if (w_is_jal) begin
            w_next_pc = r_pc + w_imm_j;
            w_pred    = 1'b1;
        end else if (w_is_bwd_branch) begin
            w_next_pc = r_pc + w_imm_b;
            w_pred    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Cache tag/data storage (no reset: validity is tracked separately)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_fill_wr) begin
            r_tag[w_fill_index]  <= mem_addr[31:INDEX_W+2];
            r_data[w_fill_index] <= mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM, PC, valid bits and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_fetch;
            r_pc           <= '0;
            r_valid        <= '0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
            inst_pred_jump <= 1'b0;
        end else if (rdy) begin
            // An accepted word leaves the register unless a new one replaces it.
            if (inst_valid && inst_ready) begin
                inst_valid <= 1'b0;
            end

            if (r_state == c_st_fetch) begin
                // A redirect suppresses the lookup for this cycle entirely.
                if (!redirect) begin
                    if (w_hit) begin
                        if (w_out_free) begin
                            inst_valid     <= 1'b1;
                            inst           <= w_word;
                            inst_pc        <= r_pc;
                            inst_pred_jump <= w_pred;
                            r_pc           <= w_next_pc;
                        end
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= {r_pc[31:2], 2'b00};
                        r_state  <= c_st_miss_wait;
                    end
                end
            end else begin
                // The fill always completes, even across a redirect; the word
                // is never forwarded, so the next FETCH cycle re-looks it up.
                if (mem_done) begin
                    r_valid[w_fill_index] <= 1'b1;
                    mem_req               <= 1'b0;
                    r_state               <= c_st_fetch;
                end
            end

            if (redirect) begin
                r_pc       <= redirect_pc;
                inst_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetcher
// Description : Scoreboard bench for if_fetcher. Expected transfers are queued
//               by the stimulus; a negedge monitor pops and compares on every
//               accepted instruction. A memory responder is folded into tick().
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_pred_jump;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    if_fetcher #(.ICACHE_LINES(256), .INDEX_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_done       (mem_done),
        .mem_data       (mem_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pred_jump (inst_pred_jump),
        .inst_ready     (inst_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        pred;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        m_e;
    int          n_vec = 0;
    int          n_err = 0;
    logic        resp_en = 1'b1;
    int          resp_cnt = 0;
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] w, input logic p);
        exp_t e;
        e.pc = pc; e.word = w; e.pred = p;
        exp_q.push_back(e);
    endtask

    // One clock step; inputs change 1 time unit after the edge. The automatic
    // memory controller answers three cycles after it first sees mem_req.
    task automatic tick();
        @(posedge clk); #1;
        if (mem_done) begin
            mem_done = 1'b0;
        end else if (resp_en && mem_req) begin
            if (resp_cnt == 2) begin
                mem_data = mem_rd(mem_addr);
                mem_done = 1'b1;
                resp_cnt = 0;
            end else begin
                resp_cnt++;
            end
        end else begin
            resp_cnt = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        inst_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        inst_ready = 1'b0;
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0 pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!inst_valid && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic manual_fill(input string name);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'b0, mem_req}, 32'd1);
        mem_data = mem_rd(mem_addr);
        mem_done = 1'b1;
        tick();
    endtask

    task automatic quiesce();
        inst_ready = 1'b0;
        repeat (20) tick();
        resp_en = 1'b0;
        check("quiet_mem_req", {31'b0, mem_req}, 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && rdy && inst_valid && inst_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_xfer: got pc 0x%08h expected no transfer", inst_pc);
            end else begin
                m_e = exp_q.pop_front();
                check("xfer_pc",   inst_pc, m_e.pc);
                check("xfer_inst", inst,    m_e.word);
                check("xfer_pred", {31'b0, inst_pred_jump}, {31'b0, m_e.pred});
            end
        end
    end

    initial begin
        mem[32'h0000_0008] = 32'h0100_006F;  // jal x0, +16 -> 0x18
        mem[32'h0000_0020] = 32'hFE00_0CE3;  // beq x0,x0,-8 -> 0x18
        mem[32'h0000_0040] = 32'h0010_0093;  // addi x1,x0,1
        mem[32'h0000_0400] = 32'h0020_0113;  // addi x2,x0,2

        // Reset state
        repeat (3) tick();
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst",       inst,                32'd0);
        check("rst_inst_pc",    inst_pc,             32'd0);
        check("rst_pred",       {31'b0, inst_pred_jump}, 32'd0);
        check("rst_mem_req",    {31'b0, mem_req},    32'd0);
        check("rst_mem_addr",   mem_addr,            32'd0);

        // Cold start
        rst = 1'b0;
        inst_ready = 1'b1;
        push(32'h0, 32'h13, 1'b0);
        tick();
        check("cold_mem_req",  {31'b0, mem_req}, 32'd1);
        check("cold_mem_addr", mem_addr,         32'h0);
        drain(100);
        check("next_mem_req",  {31'b0, mem_req}, 32'd1);
        check("next_mem_addr", mem_addr,         32'h4);

        // Backpressure
        wait_valid("bp_valid", 40);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_pc",    inst_pc,             32'h4);
            check("bp_hold_valid", {31'b0, inst_valid}, 32'd1);
            tick();
        end
        check("bp_hold_inst", inst, 32'h13);

        // Release: 0x4, 0x8 (JAL), 0x18, 0x1C, 0x20 (backward branch), 0x18
        push(32'h04, 32'h0000_0013, 1'b0);
        push(32'h08, 32'h0100_006F, 1'b1);
        push(32'h18, 32'h0000_0013, 1'b0);
        push(32'h1C, 32'h0000_0013, 1'b0);
        push(32'h20, 32'hFE00_0CE3, 1'b1);
        push(32'h18, 32'h0000_0013, 1'b0);
        drain(300);

        // Evict line 8 through its alias, then place a forward branch at 0x20
        do_redirect(32'h420);
        check("redir_clears_valid", {31'b0, inst_valid}, 32'd0);
        push(32'h420, 32'h13, 1'b0);
        drain(100);
        mem[32'h0000_0020] = 32'h0000_0463;  // beq x0,x0,+8 (forward)
        do_redirect(32'h20);
        push(32'h20, 32'h0000_0463, 1'b0);
        push(32'h24, 32'h0000_0013, 1'b0);
        drain(100);

        // Redirect during miss
        quiesce();
        do_redirect(32'h40);
        tick();
        check("rm_req",  {31'b0, mem_req}, 32'd1);
        check("rm_addr", mem_addr,         32'h40);
        do_redirect(32'h100);
        repeat (3) tick();
        check("rm_req_held",  {31'b0, mem_req}, 32'd1);
        check("rm_addr_held", mem_addr,         32'h40);
        manual_fill("rm_fill_req");
        check("rm_req_drop", {31'b0, mem_req}, 32'd0);
        tick();
        check("rm_req2",  {31'b0, mem_req}, 32'd1);
        check("rm_addr2", mem_addr,         32'h100);
        resp_en = 1'b1;
        push(32'h100, 32'h13, 1'b0);
        push(32'h104, 32'h13, 1'b0);
        drain(100);

        // Line 0x40 was written by the redirected-over fill: it hits
        quiesce();
        do_redirect(32'h40);
        tick();
        check("l40_valid", {31'b0, inst_valid}, 32'd1);
        check("l40_pc",    inst_pc,             32'h40);
        check("l40_inst",  inst,                32'h0010_0093);
        check("l40_noreq", {31'b0, mem_req},    32'd0);
        tick();
        check("l44_req",  {31'b0, mem_req}, 32'd1);
        check("l44_addr", mem_addr,         32'h44);

        // rdy=0 with a mem_done pulse: ignored
        rdy      = 1'b0;
        mem_data = 32'hDEAD_BEEF;
        mem_done = 1'b1;
        tick();
        tick();
        check("rdy0_req",   {31'b0, mem_req},    32'd1);
        check("rdy0_addr",  mem_addr,            32'h44);
        check("rdy0_valid", {31'b0, inst_valid}, 32'd1);
        check("rdy0_pc",    inst_pc,             32'h40);
        check("rdy0_inst",  inst,                32'h0010_0093);
        rdy = 1'b1;
        tick();
        tick();
        check("rdy1_req_still", {31'b0, mem_req}, 32'd1);
        manual_fill("l44_fill_req");
        resp_en = 1'b1;
        push(32'h40, 32'h0010_0093, 1'b0);
        push(32'h44, 32'h0000_0013, 1'b0);
        drain(100);

        // Aliasing on line 0
        quiesce();
        do_redirect(32'h0);
        tick();
        check("al0_valid", {31'b0, inst_valid}, 32'd1);
        check("al0_pc",    inst_pc,             32'h0);
        check("al0_noreq", {31'b0, mem_req},    32'd0);
        do_redirect(32'h400);
        tick();
        check("al400_req",  {31'b0, mem_req}, 32'd1);
        check("al400_addr", mem_addr,         32'h400);
        manual_fill("al400_fill_req");
        wait_valid("al400_valid", 20);
        check("al400_pc",   inst_pc, 32'h400);
        check("al400_inst", inst,    32'h0020_0113);
        manual_fill("al404_fill_req");
        do_redirect(32'h0);
        tick();
        check("re0_req",  {31'b0, mem_req}, 32'd1);
        check("re0_addr", mem_addr,         32'h0);
        resp_en = 1'b1;
        push(32'h0, 32'h13, 1'b0);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
